// File: rtl/gaussian_stream_filter.sv
// gaussian_stream_filter: streaming 3x3 Gaussian smoothing stage ([1 2 1;2 4 2;1 2 1]/16)
// with replicated-edge borders, two internal line buffers and valid/ready on both sides.
// Build option: define GAUSS_ROUND_EN for round-half-up output, otherwise the sum is truncated.
// Window columns are stored raw as {top, mid, bot}; border clamping is applied at the taps
// using the output-centre row/column counters.
module gaussian_stream_filter #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eol
);
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H + 2);
  localparam int SUM_W = DATA_W + 4;
  localparam int VEC_W = 3 * DATA_W;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t             state_r, state_s;
  logic [COL_W-1:0]   in_col_r, out_col_r, col_sel_s;
  logic [ROW_W-1:0]   in_row_r, out_row_r;
  logic [VEC_W-1:0]   win_b_r, win_c_r, new_col_s, left_s, right_s;
  logic [DATA_W-1:0]  lb0_r [IMG_W];
  logic [DATA_W-1:0]  lb1_r [IMG_W];
  logic [SUM_W-1:0]   sum_s, sum_adj_s;
  logic [DATA_W-1:0]  pix_s;
  logic               slot_s, accept_s, sof_start_s, step_s, gen_s;
  logic               first_row_s, last_row_s, first_col_s, last_col_s, last_in_s;
  logic               m_valid_r, m_sof_r, m_eol_r;
  logic [DATA_W-1:0]  m_data_r;

  // Vertical [1 2 1] sum of one window column with top/bottom replication.
  function automatic logic [SUM_W-1:0] col_sum(input logic [VEC_W-1:0] v,
                                               input logic top_clamp,
                                               input logic bot_clamp);
    logic [SUM_W-1:0] top, mid, bot;
    mid = SUM_W'(v[2*DATA_W-1:DATA_W]);
    top = top_clamp ? mid : SUM_W'(v[VEC_W-1:2*DATA_W]);
    bot = bot_clamp ? mid : SUM_W'(v[DATA_W-1:0]);
    return top + (mid << 1) + bot;
  endfunction

  assign slot_s      = !m_valid_r || m_ready;
  assign s_ready     = (state_r != FLUSH) && slot_s;
  assign accept_s    = s_valid && s_ready;
  assign sof_start_s = accept_s && s_sof;
  assign col_sel_s   = sof_start_s ? {COL_W{1'b0}} : in_col_r;
  assign new_col_s   = {lb1_r[col_sel_s], lb0_r[col_sel_s], s_data};
  assign last_in_s   = (in_row_r == ROW_LAST) && (in_col_r == COL_LAST);
  assign first_row_s = (out_row_r == {ROW_W{1'b0}});
  assign last_row_s  = (out_row_r == ROW_LAST);
  assign first_col_s = (out_col_r == {COL_W{1'b0}});
  assign last_col_s  = (out_col_r == COL_LAST);

  assign m_valid = m_valid_r;
  assign m_data  = m_data_r;
  assign m_sof   = m_sof_r;
  assign m_eol   = m_eol_r;

  // Next-state, window-step and output-generate decisions.
  always_comb begin
    state_s = state_r;
    step_s  = 1'b0;
    gen_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (sof_start_s) begin
          state_s = FILL;
          step_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (sof_start_s) begin
          step_s = 1'b1;
        end else if (accept_s) begin
          step_s = 1'b1;
          if ((in_row_r == ROW_W'(1)) && (in_col_r == COL_W'(1))) begin
            gen_s   = 1'b1;
            state_s = RUN;
          end else begin
            state_s = FILL;
          end
        end else begin
          state_s = FILL;
        end
      end
      RUN: begin
        if (sof_start_s) begin
          step_s  = 1'b1;
          state_s = FILL;
        end else if (accept_s) begin
          step_s = 1'b1;
          gen_s  = 1'b1;
          if (last_in_s) begin
            state_s = FLUSH;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      FLUSH: begin
        if (slot_s) begin
          step_s = 1'b1;
          gen_s  = 1'b1;
          if (last_row_s && last_col_s) begin
            state_s = IDLE;
          end else begin
            state_s = FLUSH;
          end
        end else begin
          state_s = FLUSH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // 3x3 kernel with clamped taps, then truncate or round to the output width.
  always_comb begin
    left_s  = first_col_s ? win_c_r : win_b_r;
    right_s = last_col_s ? win_c_r : new_col_s;
    sum_s   = col_sum(left_s, first_row_s, last_row_s)
            + (col_sum(win_c_r, first_row_s, last_row_s) << 1)
            + col_sum(right_s, first_row_s, last_row_s);
`ifdef GAUSS_ROUND_EN
    sum_adj_s = sum_s + SUM_W'(8);
`else
    sum_adj_s = sum_s;
`endif
    pix_s = sum_adj_s[SUM_W-1:4];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Input/output position counters and the sliding window columns.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_col_r  <= {COL_W{1'b0}};
      in_row_r  <= {ROW_W{1'b0}};
      out_col_r <= {COL_W{1'b0}};
      out_row_r <= {ROW_W{1'b0}};
      win_b_r   <= {VEC_W{1'b0}};
      win_c_r   <= {VEC_W{1'b0}};
    end else if (sof_start_s) begin
      in_col_r  <= COL_W'(1);
      in_row_r  <= {ROW_W{1'b0}};
      out_col_r <= {COL_W{1'b0}};
      out_row_r <= {ROW_W{1'b0}};
      win_b_r   <= {VEC_W{1'b0}};
      win_c_r   <= new_col_s;
    end else if (step_s) begin
      win_b_r <= win_c_r;
      win_c_r <= new_col_s;
      if (in_col_r == COL_LAST) begin
        in_col_r <= {COL_W{1'b0}};
        in_row_r <= in_row_r + ROW_W'(1);
      end else begin
        in_col_r <= in_col_r + COL_W'(1);
      end
      if (gen_s) begin
        if (last_col_s) begin
          out_col_r <= {COL_W{1'b0}};
          out_row_r <= last_row_s ? {ROW_W{1'b0}} : out_row_r + ROW_W'(1);
        end else begin
          out_col_r <= out_col_r + COL_W'(1);
        end
      end
      if ((state_r == FLUSH) && last_row_s && last_col_s) begin
        in_col_r <= {COL_W{1'b0}};
        in_row_r <= {ROW_W{1'b0}};
      end
    end
  end

  // Line buffers: lb0 holds the previous row, lb1 the row before that.
  always_ff @(posedge clk) begin
    if (accept_s && ((state_r != IDLE) || s_sof)) begin
      lb1_r[col_sel_s] <= lb0_r[col_sel_s];
      lb0_r[col_sel_s] <= s_data;
    end
  end

  // Output register: loads on generate, clears once the downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_r <= 1'b0;
      m_data_r  <= {DATA_W{1'b0}};
      m_sof_r   <= 1'b0;
      m_eol_r   <= 1'b0;
    end else if (gen_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= pix_s;
      m_sof_r   <= first_row_s && first_col_s;
      m_eol_r   <= last_col_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

endmodule

// File: doc/gaussian_stream_filter.md
# gaussian_stream_filter

Streaming 3x3 Gaussian smoothing stage for the Canny edge-detection pipeline, parametrised in pixel width and frame geometry. It accepts one raster-order pixel per handshake, buffers two image lines internally, and emits exactly one filtered pixel per input pixel. Output is the same frame size as the input, with replicated-edge border handling. It sits between the pixel source (memory reader or camera front end) and the gradient/Sobel stage, using valid/ready on both sides.

## Interface
- DATA_W, 8, pixel bit width (input and output)
- IMG_W, 640, pixels per line (>= 4)
- IMG_H, 480, lines per frame (>= 3)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept input pixel
- s_data  in  DATA_W  input pixel
- s_sof  in  1  qualifies s_data as pixel (0,0) of a new frame
- m_valid  out  1  output pixel valid
- m_ready  in  1  downstream accepts output
- m_data  out  DATA_W  filtered pixel
- m_sof  out  1  output is pixel (0,0)
- m_eol  out  1  output is the last pixel of a line

## Operation
- Kernel [1 2 1; 2 4 2; 1 2 1], sum/16. Sum width DATA_W+4; the result is the sum shifted right by 4 (see Configuration); no saturation is needed.
- Two line buffers of IMG_W x DATA_W, plus a 3x3 window register. Input row/column counters and output-centre row/column counters.
- Border handling: any window tap outside the frame takes the value of the nearest in-frame pixel in the same row/column (clamp). Example: corner taps replicate the corner pixel.
- Output raster index k is produced on acceptance of input index k+IMG_W+1. The last IMG_W+1 outputs are produced in FLUSH with no input.
- FSM:
  - IDLE: s_ready=1, and non-SOF input is dropped. An accepted s_sof goes to FILL, with the pixel stored as index 0.
  - FILL: the first IMG_W+1 inputs are accepted and no outputs are produced. On acceptance of input IMG_W+1 the first output is generated and the FSM goes to RUN.
  - RUN: each accepted input produces one output. Acceptance of the last input (index IMG_W*IMG_H-1) goes to FLUSH.
  - FLUSH: s_ready=0. The FSM generates IMG_W+1 outputs, one per free output slot, then returns to IDLE.
- s_sof accepted while in FILL/RUN aborts the current frame:
  - counters and window are cleared, and outputs not yet produced are discarded;
  - an already-registered m_valid output still completes;
  - the SOF pixel starts a new frame in FILL.
- m_sof=1 on output index 0. m_eol=1 when the output column = IMG_W-1.

## Timing
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, FSM=IDLE, all counters 0. s_ready=1 in the first cycle after rst deasserts. Line buffer contents are don't-care.
- Transfers occur on cycles where valid&&ready. m_valid is held with m_data/m_sof/m_eol stable until m_ready.
- s_ready = (FSM != FLUSH) && (!m_valid || m_ready). Throughput is 1 pixel/cycle with no stalls when m_ready=1.
- Pipeline latency: the output register loads on the same edge that accepts the enabling input, so m_valid rises the next cycle.
- Frame total: IMG_W*IMG_H accepted inputs produce exactly IMG_W*IMG_H outputs. The FLUSH state lasts at least IMG_W+1 cycles.
- rst asserted mid-frame clears everything on that edge. There is no output after reset until a new s_sof.

## Configuration
- GAUSS_ROUND_EN defined: output = (sum + 8) >> 4 (round half up). Max (16*(2^DATA_W-1)+8)>>4 still fits DATA_W.
- GAUSS_ROUND_EN undefined: output = sum >> 4 (truncate).

## Test plan
- Constant-100 frame, DATA_W=8, IMG_W=8, IMG_H=4, m_ready=1 -> 32 outputs, all equal to 100. m_sof on the first output; m_eol on outputs 7, 15, 23, 31. The FSM is back in IDLE after 9 flush outputs.
- Impulse 255 at (1,2), all other pixels 0, same geometry:
  - untruncated/truncate build: centre 63, 4-neighbours 31, diagonals 15, all others 0;
  - with GAUSS_ROUND_EN: 64/32/16.
- Corner replication: pixel (0,0)=160, all others 0 -> output (0,0) = (4+2+2+1)*160/16 = 90, output (1,1) = 10. Same result for both builds.
- Random m_ready (50%) and random s_valid gaps -> the output sequence is bit-identical to the free-running run. No output changes while stalled, and s_ready never rises while m_valid && !m_ready.
- s_sof reasserted at input index 13 of a frame -> the aborted frame yields no further new outputs, and the new frame's 32 outputs match reference values.
- rst pulsed at input index 20 -> the next cycle shows m_valid=0 and s_ready=1. A following full frame produces correct outputs.
